// File: rtl/filter_pkt_gate.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// filter_pkt_gate
//   Holds incoming AXI-Stream packets in a first-word-fall-through FIFO until
//   the packet filter publishes a verdict for the packet at the FIFO head.
//   With a forward verdict the head packet is presented on m_axis. With a drop
//   verdict it is popped silently. In both cases hdr_clear pulses for one
//   cycle once the last beat has left the FIFO. The filter keeps send_rd high
//   until it has seen hdr_clear. After that pulse the gate waits for send_rd to
//   fall before it accepts a new verdict, so a stale verdict is never reused.
//
// Ports
//   axi_aclk, axi_aresetn      clock, synchronous active-low reset
//   s_axis_*                   input stream (tdata/tkeep/tuser/tvalid/tlast/tready)
//   m_axis_*                   output stream, driven from the FIFO head
//   send, send_rd              verdict (1 = forward) and verdict-valid from filter
//   hdr_clear                  one-cycle pulse when the verdict has been consumed
//   fwd_count, drop_count      wrapping packet counters
// -----------------------------------------------------------------------------
module filter_pkt_gate #(
   parameter int C_M_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int FIFO_DEPTH_BITS      = 5
) (
   input  logic                                 axi_aclk,
   input  logic                                 axi_aresetn,

   input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
   input  logic                                 s_axis_tvalid,
   input  logic                                 s_axis_tlast,
   output logic                                 s_axis_tready,

   output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
   output logic                                 m_axis_tvalid,
   output logic                                 m_axis_tlast,
   input  logic                                 m_axis_tready,

   input  logic                                 send,
   input  logic                                 send_rd,
   output logic                                 hdr_clear,
   output logic [31:0]                          fwd_count,
   output logic [31:0]                          drop_count
);

   localparam int DW    = C_M_AXIS_DATA_WIDTH;
   localparam int KW    = C_M_AXIS_DATA_WIDTH / 8;
   localparam int UW    = C_M_AXIS_TUSER_WIDTH;
   localparam int EW    = DW + KW + UW + 1;
   localparam int DEPTH = 1 << FIFO_DEPTH_BITS;

   // The forward and drop phases share one state; the latched verdict (dec)
   // selects which of the two behaviours applies while in ST_XFER.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_CLR  = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   state_t                 state;
   logic                   dec;

   logic [EW-1:0]          mem [DEPTH];
   logic [FIFO_DEPTH_BITS:0] wr_ptr;
   logic [FIFO_DEPTH_BITS:0] rd_ptr;

   logic                   full;
   logic                   empty;
   logic                   push;
   logic                   pop;
   logic                   out_valid;
   logic [EW-1:0]          head;
   logic                   head_last;
   logic                   pkt_done;

   // ---------------------------------------------------------------------------
   // FIFO status from registered pointers only (extra bit marks wrap)
   // ---------------------------------------------------------------------------
   assign full      = (wr_ptr ^ rd_ptr) == {1'b1, {FIFO_DEPTH_BITS{1'b0}}};
   assign empty     = (wr_ptr == rd_ptr);
   assign push      = s_axis_tvalid & ~full;
   assign head      = mem[rd_ptr[FIFO_DEPTH_BITS-1:0]];
   assign head_last = head[0];

   assign s_axis_tready = ~full;

   // Forward phase presents the head; drop phase pops whenever data is present.
   assign out_valid = (state == ST_XFER) & dec & ~empty;
   assign pop       = (state == ST_XFER) & ~empty & (~dec | m_axis_tready);
   assign pkt_done  = pop & head_last;

   // Outputs are forced to zero while not valid so that the FIFO's
   // uninitialised storage never appears on the port.
   always_comb begin
      m_axis_tvalid = out_valid;
      m_axis_tdata  = '0;
      m_axis_tkeep  = '0;
      m_axis_tuser  = '0;
      m_axis_tlast  = 1'b0;
      if (out_valid) begin
         m_axis_tdata = head[EW-1 -: DW];
         m_axis_tkeep = head[UW+1 +: KW];
         m_axis_tuser = head[1 +: UW];
         m_axis_tlast = head_last;
      end
   end

   // ---------------------------------------------------------------------------
   // FIFO storage (contents need no reset; pointers define validity)
   // ---------------------------------------------------------------------------
   always_ff @(posedge axi_aclk) begin
      if (push) begin
         mem[wr_ptr[FIFO_DEPTH_BITS-1:0]] <= {s_axis_tdata, s_axis_tkeep,
                                             s_axis_tuser, s_axis_tlast};
      end
   end

   // ---------------------------------------------------------------------------
   // Pointers, verdict FSM, hdr_clear and counters
   // ---------------------------------------------------------------------------
   always_ff @(posedge axi_aclk) begin
      if (!axi_aresetn) begin
         state      <= ST_IDLE;
         dec        <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         hdr_clear  <= 1'b0;
         fwd_count  <= '0;
         drop_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end

         hdr_clear <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (send_rd) begin
                  dec   <= send;
                  state <= ST_XFER;
               end
            end

            ST_XFER: begin
               if (pkt_done) begin
                  state     <= ST_CLR;
                  hdr_clear <= 1'b1;
                  if (dec) begin
                     fwd_count <= fwd_count + 32'd1;
                  end else begin
                     drop_count <= drop_count + 32'd1;
                  end
               end
            end

            ST_CLR: begin
               state <= ST_HOLD;
            end

            ST_HOLD: begin
               // send_rd is still the old verdict until the filter drops it.
               if (!send_rd) begin
                  state <= ST_IDLE;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_filter_pkt_gate.sv
`timescale 1ns/1ps
module tb_filter_pkt_gate;

   localparam int DW = 256;
   localparam int KW = 32;
   localparam int UW = 128;

   logic           axi_aclk = 1'b0;
   logic           axi_aresetn = 1'b0;
   logic [DW-1:0]  s_axis_tdata = '0;
   logic [KW-1:0]  s_axis_tkeep = '0;
   logic [UW-1:0]  s_axis_tuser = '0;
   logic           s_axis_tvalid = 1'b0;
   logic           s_axis_tlast = 1'b0;
   logic           s_axis_tready;
   logic [DW-1:0]  m_axis_tdata;
   logic [KW-1:0]  m_axis_tkeep;
   logic [UW-1:0]  m_axis_tuser;
   logic           m_axis_tvalid;
   logic           m_axis_tlast;
   logic           m_axis_tready = 1'b0;
   logic           send = 1'b0;
   logic           send_rd = 1'b0;
   logic           hdr_clear;
   logic [31:0]    fwd_count;
   logic [31:0]    drop_count;

   filter_pkt_gate #(
      .C_M_AXIS_DATA_WIDTH  (DW),
      .C_S_AXIS_DATA_WIDTH  (DW),
      .C_M_AXIS_TUSER_WIDTH (UW),
      .C_S_AXIS_TUSER_WIDTH (UW),
      .FIFO_DEPTH_BITS      (5)
   ) dut (
      .axi_aclk      (axi_aclk),
      .axi_aresetn   (axi_aresetn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .send          (send),
      .send_rd       (send_rd),
      .hdr_clear     (hdr_clear),
      .fwd_count     (fwd_count),
      .drop_count    (drop_count)
   );

   always #5 axi_aclk = ~axi_aclk;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic [UW-1:0] u;
      logic          l;
   } beat_t;

   typedef struct {
      bit sv, sl, rd, sd, mr;
      bit ev, ehc;
      int fc, dc, ed;
      bit el;
   } vec_t;

   beat_t in_q[$];
   beat_t exp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   int    hc_seen = 0;
   int    rise_cnt = 0;
   int    rise_cyc = 0;
   int    pushed = 0;
   int    first_full = -1;
   int    exp_fwd = 0;
   int    exp_drop = 0;
   bit    mon_en = 1'b0;
   int    rdy_mode = 3;   // 0 low, 1 high, 2 random, 3 manual

   always @(posedge axi_aclk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic chkb(input string name, input beat_t act, input beat_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic beat_t out_beat();
      beat_t b;
      b.d = m_axis_tdata;
      b.k = m_axis_tkeep;
      b.u = m_axis_tuser;
      b.l = m_axis_tlast;
      return b;
   endfunction

   function automatic beat_t mk_beat(input bit last);
      beat_t b;
      for (int i = 0; i < DW / 32; i++) b.d[i*32 +: 32] = $urandom;
      for (int i = 0; i < UW / 32; i++) b.u[i*32 +: 32] = $urandom;
      b.k = $urandom;
      b.l = last;
      return b;
   endfunction

   // Reference model: a forwarded packet contributes all its beats, in order,
   // to the expected output stream; a dropped packet contributes nothing.
   task automatic add_pkt(input int len, input bit v);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b = mk_beat(i == len - 1);
         in_q.push_back(b);
         if (v) exp_q.push_back(b);
      end
   endtask

   // m_axis_tready driver
   initial begin
      forever begin
         @(posedge axi_aclk);
         #1;
         case (rdy_mode)
            0: m_axis_tready = 1'b0;
            1: m_axis_tready = 1'b1;
            2: m_axis_tready = 1'($urandom_range(1, 0));
            default: ;
         endcase
      end
   end

   // Output monitor / scoreboard
   initial begin : monitor
      bit    stall;
      bit    prev_hc;
      bit    prev_v;
      beat_t held;
      beat_t cur;
      beat_t e;
      stall = 0; prev_hc = 0; prev_v = 0;
      forever begin
         @(negedge axi_aclk);
         if (!axi_aresetn || !mon_en) begin
            stall = 0; prev_hc = 0; prev_v = 0;
            continue;
         end
         if (hdr_clear) begin
            hc_seen++;
            if (prev_hc) chk("hdr_clear_width", 2, 1);
         end
         prev_hc = hdr_clear;
         if (m_axis_tvalid && !prev_v) begin
            rise_cnt++;
            rise_cyc = cyc;
         end
         prev_v = m_axis_tvalid;
         if (m_axis_tvalid) begin
            cur = out_beat();
            if (stall) chkb("hold_stable", cur, held);
            if (m_axis_tready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_beat", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chkb("out_beat", cur, e);
               end
               stall = 0;
            end else begin
               stall = 1;
               held  = cur;
            end
         end else begin
            if (stall) chk("valid_dropped", 0, 1);
            stall = 0;
         end
      end
   end

   task automatic do_reset();
      axi_aresetn   = 1'b0;
      s_axis_tvalid = 1'b0;
      send_rd       = 1'b0;
      send          = 1'b0;
      repeat (2) @(posedge axi_aclk);
      #1;
      axi_aresetn = 1'b1;
      in_q.delete();
      exp_q.delete();
      exp_fwd = 0;
      exp_drop = 0;
   endtask

   task automatic drive_pkts(input int gap_max);
      beat_t b;
      bit    ok;
      while (in_q.size() > 0) begin
         b = in_q.pop_front();
         if (gap_max > 0) begin
            repeat ($urandom_range(gap_max, 0)) begin
               s_axis_tvalid = 1'b0;
               @(posedge axi_aclk);
               #1;
            end
         end
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = b.d;
         s_axis_tkeep  = b.k;
         s_axis_tuser  = b.u;
         s_axis_tlast  = b.l;
         ok = 0;
         for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge axi_aclk);
            if (s_axis_tready) ok = 1;
            else if (first_full < 0) first_full = pushed;
            @(posedge axi_aclk);
            #1;
         end
         if (!ok) chk("drive_timeout", 0, 1);
         else pushed++;
      end
      s_axis_tvalid = 1'b0;
   endtask

   // Acts as the filter for one packet: verdict until hdr_clear, then h more
   // cycles of a stale send_rd, then one cycle low. send wanders meanwhile.
   task automatic give_verdict(input bit v, input int h, output int lat, output int t0);
      int  hc0;
      bit  got;
      hc0 = hc_seen;
      send_rd = 1'b1;
      send    = v;
      t0      = cyc;
      got     = 0;
      lat     = -1;
      for (int i = 0; i < 3000 && !got; i++) begin
         @(negedge axi_aclk);
         if (hdr_clear) begin
            got = 1;
            lat = cyc - t0;
         end
         @(posedge axi_aclk);
         #1;
         send = 1'($urandom_range(1, 0));
      end
      if (!got) chk("verdict_timeout", 0, 1);
      if (v) exp_fwd++;
      else exp_drop++;
      repeat (h) begin
         @(posedge axi_aclk);
         #1;
         send = 1'($urandom_range(1, 0));
      end
      send_rd = 1'b0;
      @(posedge axi_aclk);
      #1;
      chk("hdr_clear_pulses", hc_seen - hc0, 1);
      chk("fwd_count", int'(fwd_count), exp_fwd);
      chk("drop_count", int'(drop_count), exp_drop);
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      vec_t  tbl[23];
      beat_t eb;
      int    lat, t0, hc0, rc0, n;
      bit    verd[12];

      //          sv sl rd sd mr  ev ehc fc dc ed el
      tbl[0]  = '{0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0};
      tbl[1]  = '{1, 1, 0, 0, 0,  0, 0,  0, 0, 0, 0};
      tbl[2]  = '{0, 0, 1, 1, 0,  0, 0,  0, 0, 0, 0};
      tbl[3]  = '{0, 0, 1, 1, 0,  1, 0,  0, 0, 1, 1};
      tbl[4]  = '{0, 0, 1, 1, 1,  1, 0,  0, 0, 1, 1};
      tbl[5]  = '{0, 0, 1, 1, 0,  0, 1,  1, 0, 0, 0};
      tbl[6]  = '{0, 0, 1, 1, 0,  0, 0,  1, 0, 0, 0};
      tbl[7]  = '{0, 0, 0, 0, 0,  0, 0,  1, 0, 0, 0};
      tbl[8]  = '{0, 0, 0, 0, 0,  0, 0,  1, 0, 0, 0};
      tbl[9]  = '{1, 1, 0, 0, 0,  0, 0,  1, 0, 0, 0};
      tbl[10] = '{0, 0, 1, 0, 0,  0, 0,  1, 0, 0, 0};
      tbl[11] = '{0, 0, 1, 1, 1,  0, 0,  1, 0, 0, 0};
      tbl[12] = '{0, 0, 1, 1, 0,  0, 1,  1, 1, 0, 0};
      tbl[13] = '{0, 0, 1, 0, 0,  0, 0,  1, 1, 0, 0};
      tbl[14] = '{0, 0, 0, 0, 0,  0, 0,  1, 1, 0, 0};
      tbl[15] = '{0, 0, 0, 0, 0,  0, 0,  1, 1, 0, 0};
      tbl[16] = '{0, 0, 1, 1, 0,  0, 0,  1, 1, 0, 0};
      tbl[17] = '{1, 0, 1, 1, 1,  0, 0,  1, 1, 0, 0};
      tbl[18] = '{1, 1, 1, 0, 1,  1, 0,  1, 1, 17, 0};
      tbl[19] = '{0, 0, 1, 0, 1,  1, 0,  1, 1, 18, 1};
      tbl[20] = '{0, 0, 1, 0, 0,  0, 1,  2, 1, 0, 0};
      tbl[21] = '{0, 0, 0, 0, 0,  0, 0,  2, 1, 0, 0};
      tbl[22] = '{0, 0, 0, 0, 0,  0, 0,  2, 1, 0, 0};

      // ---------------- table-driven cycle vectors ----------------
      rdy_mode = 3;
      do_reset();
      for (int i = 0; i < 23; i++) begin
         s_axis_tvalid = tbl[i].sv;
         s_axis_tlast  = tbl[i].sl;
         s_axis_tdata  = {8{32'(i)}};
         s_axis_tkeep  = '1;
         s_axis_tuser  = {4{32'(i)}};
         send_rd       = tbl[i].rd;
         send          = tbl[i].sd;
         m_axis_tready = tbl[i].mr;
         @(negedge axi_aclk);
         chk($sformatf("tbl%0d_valid", i), int'(m_axis_tvalid), int'(tbl[i].ev));
         chk($sformatf("tbl%0d_hdr_clear", i), int'(hdr_clear), int'(tbl[i].ehc));
         chk($sformatf("tbl%0d_s_tready", i), int'(s_axis_tready), 1);
         chk($sformatf("tbl%0d_fwd", i), int'(fwd_count), tbl[i].fc);
         chk($sformatf("tbl%0d_drop", i), int'(drop_count), tbl[i].dc);
         if (i == 0) chkb("reset_outputs", out_beat(), '0);
         if (tbl[i].ev) begin
            eb.d = {8{32'(tbl[i].ed)}};
            eb.k = '1;
            eb.u = {4{32'(tbl[i].ed)}};
            eb.l = tbl[i].el;
            chkb($sformatf("tbl%0d_beat", i), out_beat(), eb);
         end
         @(posedge axi_aclk);
         #1;
      end
      s_axis_tvalid = 1'b0;
      send_rd = 1'b0;

      // ---------------- 1: forward 3-beat packet ----------------
      do_reset();
      mon_en = 1'b1;
      rdy_mode = 1;
      add_pkt(3, 1);
      drive_pkts(0);
      give_verdict(1, 1, lat, t0);
      chk("t1_clear_latency", lat, 4);
      chk("t1_first_beat_latency", rise_cyc - t0, 1);
      chk("t1_all_beats_out", exp_q.size(), 0);

      // ---------------- 2: drop 4-beat packet ----------------
      add_pkt(4, 0);
      drive_pkts(0);
      rc0 = rise_cnt;
      give_verdict(0, 1, lat, t0);
      chk("t2_clear_latency", lat, 5);
      chk("t2_no_valid", rise_cnt - rc0, 0);

      // ---------------- 3: stale send_rd, next packet queued ----------------
      add_pkt(2, 1);
      add_pkt(3, 0);
      drive_pkts(0);
      give_verdict(1, 2, lat, t0);
      hc0 = hc_seen;
      rc0 = rise_cnt;
      repeat (6) @(posedge axi_aclk);
      #1;
      chk("t3_no_stale_clear", hc_seen - hc0, 0);
      chk("t3_no_stale_valid", rise_cnt - rc0, 0);
      give_verdict(0, 1, lat, t0);
      chk("t3_second_drop_latency", lat, 4);

      // ---------------- 4: 40 beats into 32-deep FIFO ----------------
      do_reset();
      rdy_mode = 0;
      pushed = 0;
      first_full = -1;
      add_pkt(40, 1);
      fork
         drive_pkts(0);
         give_verdict(1, 1, lat, t0);
         begin
            repeat (70) @(posedge axi_aclk);
            rdy_mode = 1;
         end
      join
      chk("t4_full_after", first_full, 32);
      chk("t4_pushed", pushed, 40);
      chk("t4_drained", exp_q.size(), 0);

      // ---------------- 5: A fwd, B drop, random ready ----------------
      do_reset();
      rdy_mode = 2;
      add_pkt(int'($urandom_range(6, 2)), 1);
      add_pkt(int'($urandom_range(6, 1)), 0);
      hc0 = hc_seen;
      fork
         drive_pkts(0);
         begin
            give_verdict(1, 1, lat, t0);
            give_verdict(0, 1, lat, t0);
         end
      join
      chk("t5_pulses", hc_seen - hc0, 2);
      chk("t5_only_a", exp_q.size(), 0);

      // ---------------- random packets ----------------
      do_reset();
      rdy_mode = 2;
      for (int k = 0; k < 12; k++) begin
         verd[k] = 1'($urandom_range(1, 0));
         n = int'($urandom_range(40, 1));
         add_pkt(n, verd[k]);
      end
      fork
         drive_pkts(2);
         begin
            for (int k = 0; k < 12; k++) begin
               give_verdict(verd[k], int'($urandom_range(2, 1)), lat, t0);
               repeat ($urandom_range(3, 0)) @(posedge axi_aclk);
               #1;
            end
         end
      join
      chk("rand_exp_empty", exp_q.size(), 0);

      // ---------------- 6: reset mid-forward ----------------
      do_reset();
      rdy_mode = 1;
      add_pkt(5, 1);
      drive_pkts(0);
      send_rd = 1'b1;
      send = 1'b1;
      n = 0;
      for (int i = 0; i < 20 && n == 0; i++) begin
         @(negedge axi_aclk);
         if (m_axis_tvalid) n = 1;
      end
      chk("t6_started", n, 1);
      hc0 = hc_seen;
      @(posedge axi_aclk);
      #1;
      axi_aresetn = 1'b0;
      @(posedge axi_aclk);
      #1;
      axi_aresetn = 1'b1;
      send_rd = 1'b0;
      exp_q.delete();
      @(negedge axi_aclk);
      chk("t6_valid", int'(m_axis_tvalid), 0);
      chk("t6_hdr_clear", int'(hdr_clear), 0);
      chk("t6_s_tready", int'(s_axis_tready), 1);
      chk("t6_fwd", int'(fwd_count), 0);
      chk("t6_drop", int'(drop_count), 0);
      repeat (5) @(posedge axi_aclk);
      #1;
      chk("t6_no_clear_after", hc_seen - hc0, 0);
      chk("t6_idle", int'(m_axis_tvalid), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
